// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select add/subtract unit with optional signed saturation.
// The block chain is split evenly over STAGES registered stages with a
// valid/ready handshake on both sides and bubble-collapsing stage valids.
//
// Ports:
//   clk, rst            - rising-edge clock, async active-high reset
//   in_valid/in_ready   - operand handshake (a, b, cin, sub, sat)
//   out_valid/out_ready - result handshake (sum, cout, overflow)
//   sub                 - 1: a - b - cin (cin acts as borrow-in)
//   sat                 - 1: clamp sum to signed range on overflow
//   cout                - raw carry out of MSB (sub: 1 = no borrow)
//   overflow            - signed overflow, before saturation
module pipelined_csel_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int BPS  = NBLK / STAGES;
    localparam int L    = STAGES - 1;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
    } part_t;

    // Adds the BPS blocks owned by group g on top of partial sum p.
    // Each block precomputes both carry-in cases; the incoming carry
    // only drives the final mux, so the ripple is one mux per block.
    function automatic part_t add_grp(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] p,
        input logic             ci,
        input int               g
    );
        part_t          r;
        logic [BLOCK:0] r0;
        logic [BLOCK:0] r1;
        int             lo;
        r.s = p;
        r.c = ci;
        for (int j = 0; j < BPS; j++) begin
            lo = (g * BPS + j) * BLOCK;
            r0 = {1'b0, x[lo+:BLOCK]} + {1'b0, y[lo+:BLOCK]};
            r1 = {1'b0, x[lo+:BLOCK]} + {1'b0, y[lo+:BLOCK]}
               + {{BLOCK{1'b0}}, 1'b1};
            r.s[lo+:BLOCK] = r.c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
            r.c = r.c ? r1[BLOCK] : r0[BLOCK];
        end
        return r;
    endfunction

    // Per-stage state: operands (b already conditioned for sub),
    // partial sum, carry into the next group and the sat request.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             sat_q [STAGES];
    logic             sat_d [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] ld_en;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             nxt_ok;
    part_t            p;

    logic [WIDTH-1:0] raw;
    logic             msb_cin;
    logic             ovf;

    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub ? ~cin : cin;

        // A stage may load when empty or when its content moves on.
        nxt_ok = out_ready;
        ld_en  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld_en[k] = !v_q[k] || nxt_ok;
            nxt_ok   = ld_en[k];
        end

        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        sat_d = sat_q;
        v_d   = v_q;

        v_d[0] = ld_en[0] ? in_valid : v_q[0];
        p = add_grp(a, b_eff, '0, c0, 0);
        if (ld_en[0] && in_valid) begin
            a_d[0]   = a;
            b_d[0]   = b_eff;
            s_d[0]   = p.s;
            c_d[0]   = p.c;
            sat_d[0] = sat;
        end

        for (int k = 1; k < STAGES; k++) begin
            v_d[k] = ld_en[k] ? v_q[k-1] : v_q[k];
            p = add_grp(a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], k);
            if (ld_en[k] && v_q[k-1]) begin
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                s_d[k]   = p.s;
                c_d[k]   = p.c;
                sat_d[k] = sat_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sat_q[k] <= 1'b0;
            end
        end else begin
            v_q   <= v_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            sat_q <= sat_d;
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit itself.
    always_comb begin
        raw     = s_q[L];
        msb_cin = a_q[L][WIDTH-1] ^ b_q[L][WIDTH-1] ^ raw[WIDTH-1];
        ovf     = msb_cin ^ c_q[L];
        sum     = raw;
        if (sat_q[L] && ovf) begin
            sum = a_q[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    assign overflow  = ovf;
    assign cout      = c_q[L];
    assign out_valid = v_q[L];
    assign in_ready  = ld_en[0];

endmodule

// File: doc/pipelined_csel_adder.md
PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Parameters
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits, minimum 8.
REQ-002 SHALL have parameter BLOCK, default 4: carry-select block width; WIDTH divisible by BLOCK.
REQ-003 SHALL have parameter STAGES, default 2: pipeline register stages, minimum 1; (WIDTH/BLOCK) divisible by STAGES.

Interface
REQ-004 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: operand set present.
REQ-007 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-008 SHALL have port a, input, WIDTH: operand A, two's complement.
REQ-009 SHALL have port b, input, WIDTH: operand B, two's complement.
REQ-010 SHALL have port cin, input, 1: carry-in (add) or borrow-in (sub).
REQ-011 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-012 SHALL have port sat, input, 1: 1 = signed saturation on overflow.
REQ-013 SHALL have port out_valid, output, 1: result present.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-015 SHALL have port sum, output, WIDTH: result.
REQ-016 SHALL have port cout, output, 1: raw carry out of MSB.
REQ-017 SHALL have port overflow, output, 1: signed overflow flag (pre-saturation).

Function
REQ-018 SHALL capture a, b, cin, sub, sat on a rising edge where in_valid and in_ready are both 1; no other edge captures.
REQ-019 SHALL form b_eff = sub ? ~b : b and c0 = sub ? ~cin : cin; raw = a + b_eff + c0, modulo 2^WIDTH.
REQ-020 SHALL implement the addition as carry-select blocks of BLOCK bits (per-block precomputed sums for carry 0 and 1, muxed by incoming carry); the first block SHALL use c0 directly.
REQ-021 SHALL split the block chain evenly over STAGES register stages; each stage registers its partial sum bits, the inter-stage carry, and the unconsumed upper operand bits plus sub/sat.
REQ-022 SHALL set cout = carry out of bit WIDTH-1; in sub mode cout = 1 means no borrow.
REQ-023 SHALL set overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-024 SHALL, when sat = 1 and overflow = 1, drive sum = {0,1...1} if a[WIDTH-1] = 0, else {1,0...0}; otherwise sum = raw.
REQ-025 SHALL have latency exactly STAGES cycles from accepting edge to out_valid = 1 with no backpressure; throughput one result per cycle.
REQ-026 SHALL keep per-stage valid bits; stage k advances when stage k+1 is empty or advancing; last stage advances when out_valid = 0 or out_ready = 1.
REQ-027 SHALL drive in_ready = (stage 0 empty) OR (stage 0 advancing), combinationally; bubbles SHALL collapse.
REQ-028 SHALL hold sum, cout, overflow, out_valid stable while out_valid = 1 and out_ready = 0.
REQ-029 SHALL deliver results in acceptance order; no loss or duplication under any in_valid/out_ready pattern.
REQ-030 SHALL, on same-edge output handshake and input acceptance with a full pipeline, advance all stages and accept the new operand.

Reset
REQ-031 SHALL, while rst = 1, clear all stage valid bits immediately; out_valid = 0, sum = 0, cout = 0, overflow = 0.
REQ-032 SHALL drive in_ready = 1 from the first edge after rst deasserts; in-flight transactions at reset are discarded, never output.

Verification (WIDTH=32, BLOCK=4, STAGES=2)
REQ-033 SHALL test add a=7FFFFFFF, b=00000001, cin=0, sat=0 -> 2 cycles later sum=80000000, cout=0, overflow=1; repeat sat=1 -> sum=7FFFFFFF, overflow=1.
REQ-034 SHALL test add a=80000000, b=FFFFFFFF, sat=0 -> sum=7FFFFFFF, cout=1, overflow=1; sat=1 -> sum=80000000.
REQ-035 SHALL test sub a=00000005, b=0000000A, cin=0 -> sum=FFFFFFFB, cout=0, overflow=0; sub a=-999, b=-999 -> sum=00000000, cout=1.
REQ-036 SHALL test back-to-back stream 10+10, -10+-20, 165+1000, -500+2000 with out_ready=0 for cycles 0-4 -> in_ready=0 after 2 accepted; results 14, FFFFFFE2, 48D, 5DC in order, each held stable until taken.
REQ-037 SHALL test rst pulse with 2 transactions in flight -> out_valid=0 same cycle, neither result ever appears, next accepted 1+1 yields sum=2 after 2 cycles.
REQ-038 SHALL test random a, b, cin, sub, sat with random in_valid/out_ready against a reference model, 10,000 transactions, zero mismatches.
